// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the DCache response, aligns and extends load
// data, and hands the final result to WB while feeding forwarding info to ID.
module mem_stage #(
  parameter int M1_TO_MS_BUS_WD = 149,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       m1s_to_ms_valid,
  input  logic [M1_TO_MS_BUS_WD-1:0] m1s_to_ms_bus,
  input  logic                       data_data_ok,
  input  logic [31:0]                data_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [4:0]                 ms_dest,
  output logic [31:0]                ms_result,
  output logic                       ms_load_pending
);

  typedef struct packed {
    logic        mfc0;
    logic [31:0] cp0_data;
    logic        ex;
    logic [31:0] rt_value;
    logic [11:0] mem_inst;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } m1_ms_t;

  typedef enum logic {
    BUF_WAIT,
    BUF_HAVE
  } buf_st_e;

  m1_ms_t      bus_q;
  logic        ms_valid;
  buf_st_e     buf_st;
  logic [31:0] buf_data;

  logic        buf_valid;
  logic        need_mem;
  logic        data_ok_now;
  logic        ms_ready_go;
  logic [31:0] r;
  logic [31:0] t;
  logic [1:0]  a;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        ws_gr_we;

  assign buf_valid   = (buf_st == BUF_HAVE);
  assign need_mem    = ~bus_q.ex & (|bus_q.mem_inst);
  assign data_ok_now = data_data_ok & ms_valid & need_mem & ~buf_valid;
  assign ms_ready_go = ~need_mem | data_ok_now | buf_valid;

  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      bus_q    <= '0;
      buf_st   <= BUF_WAIT;
      buf_data <= '0;
    end else begin
      if (ms_allowin)
        ms_valid <= m1s_to_ms_valid;
      if (m1s_to_ms_valid && ms_allowin)
        bus_q <= m1_ms_t'(m1s_to_ms_bus);
      unique case (buf_st)
        BUF_WAIT:
          if (data_ok_now && !ws_allowin) begin
            buf_st   <= BUF_HAVE;
            buf_data <= data_rdata;
          end
        BUF_HAVE:
          if (ms_to_ws_valid && ws_allowin)
            buf_st <= BUF_WAIT;
        default: buf_st <= BUF_WAIT;
      endcase
    end
  end

  assign r     = buf_valid ? buf_data : data_rdata;
  assign t     = bus_q.rt_value;
  assign a     = bus_q.alu_result[1:0];
  assign rbyte = 8'(r >> {a, 3'b000});
  assign rhalf = a[1] ? r[31:16] : r[15:0];

  // mem_inst = {swr,swl,sw,sh,sb,lwr,lwl,lw,lhu,lh,lbu,lb}
  always_comb begin
    load_data = r;
    unique case (1'b1)
      bus_q.mem_inst[0]: load_data = {{24{rbyte[7]}}, rbyte};
      bus_q.mem_inst[1]: load_data = {24'b0, rbyte};
      bus_q.mem_inst[2]: load_data = {{16{rhalf[15]}}, rhalf};
      bus_q.mem_inst[3]: load_data = {16'b0, rhalf};
      bus_q.mem_inst[4]: load_data = r;
      bus_q.mem_inst[5]:
        unique case (a)
          2'd0:    load_data = {r[7:0], t[23:0]};
          2'd1:    load_data = {r[15:0], t[15:0]};
          2'd2:    load_data = {r[23:0], t[7:0]};
          default: load_data = r;
        endcase
      bus_q.mem_inst[6]:
        unique case (a)
          2'd0:    load_data = r;
          2'd1:    load_data = {t[31:24], r[31:8]};
          2'd2:    load_data = {t[31:16], r[31:16]};
          default: load_data = {t[31:8], r[31:24]};
        endcase
      default: load_data = r;
    endcase
  end

  assign final_result = bus_q.mfc0         ? bus_q.cp0_data :
                        bus_q.res_from_mem ? load_data      :
                                             bus_q.alu_result;

  assign ws_gr_we     = bus_q.gr_we & ~bus_q.ex;
  assign ms_to_ws_bus = {ws_gr_we, bus_q.dest, final_result, bus_q.pc};

  assign ms_dest   = bus_q.dest & {5{ms_valid & ws_gr_we}};
  assign ms_result = final_result;

  assign ms_load_pending = ms_valid & bus_q.res_from_mem & ~bus_q.ex
                         & ~(data_ok_now | buf_valid);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random loads/stores checked against a
// byte-level model of the MIPS load semantics.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         m1s_to_ms_valid;
  logic [148:0] m1s_to_ms_bus;
  logic         data_data_ok;
  logic [31:0]  data_rdata;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [4:0]   ms_dest;
  logic [31:0]  ms_result;
  logic         ms_load_pending;

  int n_chk = 0;
  int n_err = 0;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .m1s_to_ms_valid (m1s_to_ms_valid),
    .m1s_to_ms_bus   (m1s_to_ms_bus),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_dest         (ms_dest),
    .ms_result       (ms_result),
    .ms_load_pending (ms_load_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [148:0] mk(
    logic mfc0, logic [31:0] cp0, logic ex, logic [31:0] rt,
    logic [11:0] mi, logic rfm, logic gw, logic [4:0] d,
    logic [31:0] alu, logic [31:0] pc);
    return {mfc0, cp0, ex, rt, mi, rfm, gw, d, alu, pc};
  endfunction

  // op: 0 lb,1 lbu,2 lh,3 lhu,4 lw,5 lwl,6 lwr (memory is little-endian)
  function automatic logic [31:0] model(int op, int a,
                                        logic [31:0] r, logic [31:0] t);
    logic [7:0] rb[4];
    logic [7:0] tb[4];
    logic [7:0] ob[4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) begin
      rb[i] = r[8*i +: 8];
      tb[i] = t[8*i +: 8];
    end
    h = {rb[(a & 2) + 1], rb[a & 2]};
    case (op)
      0: return {{24{rb[a][7]}}, rb[a]};
      1: return {24'b0, rb[a]};
      2: return {{16{h[15]}}, h};
      3: return {16'b0, h};
      5: begin
        for (int i = 0; i < 4; i++)
          ob[i] = (i >= 3 - a) ? rb[i - (3 - a)] : tb[i];
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      6: begin
        for (int i = 0; i < 4; i++)
          ob[i] = (i <= 3 - a) ? rb[i + a] : tb[i];
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      default: return r;
    endcase
  endfunction

  task automatic send(logic [148:0] b);
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = b;
    ws_allowin      = 1'b1;
    @(posedge clk); #1;
    m1s_to_ms_valid = 1'b0;
    m1s_to_ms_bus   = '0;
  endtask

  task automatic mem_op(int op, int a, logic [31:0] rt, logic [31:0] rd,
                        int waits, int stall);
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] exp;
    logic [4:0]  d;
    logic        ld;
    ld  = (op <= 6);
    alu = {$urandom() >> 2, 2'(a)};
    pc  = $urandom();
    d   = 5'($urandom_range(1, 31));
    exp = ld ? model(op, a, rd, rt) : alu;
    data_data_ok = 1'b0;
    send(mk(1'b0, 32'h0, 1'b0, rt, 12'(1) << op, ld, ld, d, alu, pc));
    for (int i = 0; i < waits; i++) begin
      #3;
      chk("wait_pend", 32'(ms_load_pending), 32'(ld));
      chk("wait_valid", 32'(ms_to_ws_valid), 32'h0);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b1;
    data_rdata   = rd;
    ws_allowin   = (stall == 0);
    #3;
    chk("ok_valid", 32'(ms_to_ws_valid), 32'h1);
    chk("ok_result", ms_result, exp);
    chk("ok_pend", 32'(ms_load_pending), 32'h0);
    chk("ok_dest", 32'(ms_dest), ld ? 32'(d) : 32'h0);
    chk("ok_pc", ms_to_ws_bus[31:0], pc);
    chk("ok_gwe", 32'(ms_to_ws_bus[69]), 32'(ld));
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    if (stall > 0) begin
      data_rdata = 32'h0;
      for (int i = 1; i < stall; i++) begin
        #3;
        chk("buf_valid", 32'(ms_to_ws_valid), 32'h1);
        chk("buf_result", ms_result, exp);
        @(posedge clk); #1;
      end
      ws_allowin = 1'b1;
      #3;
      chk("buf_out_valid", 32'(ms_to_ws_valid), 32'h1);
      chk("buf_out_result", ms_result, exp);
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    #3;
    chk("drain_valid", 32'(ms_to_ws_valid), 32'h0);
    chk("drain_allowin", 32'(ms_allowin), 32'h1);
  endtask

  initial begin
    logic [31:0] v;
    resetn          = 1'b0;
    ws_allowin      = 1'b1;
    m1s_to_ms_valid = 1'b0;
    m1s_to_ms_bus   = '0;
    data_data_ok    = 1'b0;
    data_rdata      = 32'h0;
    #3;
    chk("rst_valid", 32'(ms_to_ws_valid), 32'h0);
    chk("rst_dest", 32'(ms_dest), 32'h0);
    chk("rst_result", ms_result, 32'h0);
    chk("rst_pend", 32'(ms_load_pending), 32'h0);
    chk("rst_allowin", 32'(ms_allowin), 32'h1);
    @(posedge clk); #1;
    resetn = 1'b1;

    // plain ALU op passes straight through
    send(mk(1'b0, 32'h0, 1'b0, 32'h0, 12'h0, 1'b0, 1'b1, 5'd5,
            32'h1234, 32'hBFC0_0000));
    #3;
    chk("alu_valid", 32'(ms_to_ws_valid), 32'h1);
    chk("alu_dest", 32'(ms_dest), 32'd5);
    chk("alu_result", ms_result, 32'h1234);
    chk("alu_pend", 32'(ms_load_pending), 32'h0);

    // mfc0 selects cp0 data
    v = $urandom();
    send(mk(1'b1, v, 1'b0, 32'h0, 12'h0, 1'b0, 1'b1, 5'd3,
            32'h5555, 32'h0));
    #3;
    chk("mfc0_result", ms_result, v);
    chk("mfc0_dest", 32'(ms_dest), 32'd3);

    mem_op(4, 0, 32'h0, 32'hDEADBEEF, 3, 0);
    mem_op(0, 3, 32'h0, 32'h80112233, 0, 0);
    mem_op(1, 3, 32'h0, 32'h80112233, 1, 0);
    mem_op(2, 2, 32'h0, 32'h80112233, 0, 0);
    mem_op(3, 2, 32'h0, 32'h80112233, 2, 0);
    mem_op(5, 1, 32'hAABBCCDD, 32'h11223344, 1, 0);
    mem_op(6, 2, 32'hAABBCCDD, 32'h11223344, 1, 0);
    mem_op(4, 0, 32'h0, 32'hCAFEF00D, 1, 2);
    mem_op(9, 0, 32'h0, 32'h12345678, 1, 0);

    // stray data_ok while empty must not fill the buffer
    data_data_ok = 1'b1;
    data_rdata   = 32'h99999999;
    @(posedge clk); #1;
    mem_op(4, 0, 32'h0, 32'h0BADF00D, 1, 0);

    // exception on a load: no wait, no register write
    send(mk(1'b0, 32'h0, 1'b1, 32'h0, 12'h010, 1'b1, 1'b1, 5'd8,
            32'h0, 32'h0));
    #3;
    chk("ex_valid", 32'(ms_to_ws_valid), 32'h1);
    chk("ex_dest", 32'(ms_dest), 32'h0);
    chk("ex_gwe", 32'(ms_to_ws_bus[69]), 32'h0);
    chk("ex_pend", 32'(ms_load_pending), 32'h0);
    @(posedge clk); #1;

    // reset while a load waits
    send(mk(1'b0, 32'h0, 1'b0, 32'h0, 12'h010, 1'b1, 1'b1, 5'd9,
            32'h0, 32'h0));
    #3;
    chk("rw_pend", 32'(ms_load_pending), 32'h1);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("rw_valid", 32'(ms_to_ws_valid), 32'h0);
    chk("rw_pend0", 32'(ms_load_pending), 32'h0);
    chk("rw_dest", 32'(ms_dest), 32'h0);
    chk("rw_allowin", 32'(ms_allowin), 32'h1);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int k = 0; k < 40; k++)
      mem_op($urandom_range(0, 11), $urandom_range(0, 3), $urandom(),
             $urandom(), $urandom_range(0, 3), $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
